// File: rtl/pitch_pkg.sv
// -----------------------------------------------------------------------------
// pitch_pkg
//   Shared definitions for the pitch-down effect: default widths, the
//   sample and read-position types, and buffer geometry constants.
//   No ports (package).
// -----------------------------------------------------------------------------
package pitch_pkg;

  // Default sample width and buffer address width.
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;

  // Circular buffer geometry.
  localparam int DEPTH      = 1 << ADDR_W;
  localparam int HALF_DEPTH = DEPTH / 2;

  // Signed audio sample.
  typedef logic signed [DATA_W-1:0] sample_t;

  // Read position: {integer address, one fractional bit}.
  typedef logic [ADDR_W:0] rd_pos_t;

endpackage : pitch_pkg

// File: rtl/pitch_dp_ram.sv
// -----------------------------------------------------------------------------
// pitch_dp_ram
//   Sample buffer: one write port and two independent registered read ports.
//   No reset so it maps onto block RAM. A read and a write to the same address
//   on the same edge returns the previous contents (read-first).
//
// Ports
//   i_clk      clock, all activity on posedge
//   i_we       write enable
//   i_waddr    write address
//   i_wdata    write data
//   i_re       read enable for both read ports (outputs hold when low)
//   i_raddr_a  read address, port A
//   i_raddr_b  read address, port B
//   o_q_a      registered read data, port A
//   o_q_b      registered read data, port B
// -----------------------------------------------------------------------------
module pitch_dp_ram #(
  parameter int DATA_W = pitch_pkg::DATA_W,
  parameter int ADDR_W = pitch_pkg::ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_q_a,
  output logic [DATA_W-1:0] o_q_b
);

  localparam int RAM_DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [0:RAM_DEPTH-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      o_q_a <= r_mem[i_raddr_a];
      o_q_b <= r_mem[i_raddr_b];
    end
  end

endmodule : pitch_dp_ram

// File: rtl/pitch_down.sv
// -----------------------------------------------------------------------------
// pitch_down
//   Streaming pitch-lowering effect. Every input sample is written into a
//   circular buffer; the read position advances by half a sample per input
//   sample, so the stream is stretched 2:1 in time. Half positions are filled
//   by 2-point linear interpolation. When the writer is about to lap the
//   reader, the read position jumps forward half a buffer (splice).
//
//   Strobe semantics: sample_en is a one-cycle qualifier for data_in; every
//   cycle it is high (back-to-back allowed) one sample is consumed. There is
//   no backpressure. Each consumed sample produces exactly one out_valid pulse
//   two edges later; data_out holds its value between pulses.
//
// Ports
//   Clk        system clock, all logic on posedge
//   reset      synchronous active-high reset, overrides every other input
//   sample_en  input sample strobe
//   data_in    signed input sample
//   data_out   signed pitch-lowered sample, held between updates
//   out_valid  one-cycle pulse when data_out updates
//
// Pipeline for a strobe at edge E0
//   E0: buffer write, S1 captures read addresses and fraction, read pointer
//       advances (or splices)
//   E1: registered buffer read, S2 carries fraction/valid alongside it
//   E2: interpolated result registered onto data_out, out_valid raised
// -----------------------------------------------------------------------------
module pitch_down #(
  parameter int DATA_W = pitch_pkg::DATA_W,
  parameter int ADDR_W = pitch_pkg::ADDR_W
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid
);

  import pitch_pkg::*;

  localparam int BUF_DEPTH = 1 << ADDR_W;
  localparam int BUF_HALF  = BUF_DEPTH / 2;

  // Gap value at which the writer is about to catch the reader.
  localparam logic [ADDR_W-1:0] SPLICE_GAP = ADDR_W'(BUF_DEPTH - 2);
  localparam logic [ADDR_W-1:0] HALF_STEP  = ADDR_W'(BUF_HALF);
  localparam logic [ADDR_W:0]   POS_STEP   = {{ADDR_W{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Pointer state
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_int;
  logic              r_rd_frac;

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic              r_s1_valid;
  logic              r_s1_frac;
  logic [ADDR_W-1:0] r_s1_addr_a;
  logic [ADDR_W-1:0] r_s1_addr_b;

  logic              r_s2_valid;
  logic              r_s2_frac;

  logic [DATA_W-1:0] r_data_out;
  logic              r_out_valid;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic              w_we;
  logic [ADDR_W-1:0] w_gap;
  logic              w_splice;
  logic [ADDR_W:0]   w_rd_pos;
  logic [ADDR_W:0]   w_rd_pos_inc;
  logic [DATA_W-1:0] w_q_a;
  logic [DATA_W-1:0] w_q_b;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_avg;
  logic [DATA_W-1:0] w_result;

  // A strobe that coincides with reset is dropped entirely, including the
  // buffer write.
  assign w_we = sample_en && !reset;

  // Distance from reader to writer in whole samples; wraps naturally in
  // ADDR_W bits.
  assign w_gap = r_wr_ptr - r_rd_int;

  // The splice is taken only at integer read positions, so the exact
  // writer-to-reader distance is DEPTH-2 when it fires. This keeps at least
  // DEPTH/2-1 samples of history behind the reader after every jump.
  assign w_splice = (w_gap == SPLICE_GAP) && !r_rd_frac;

  assign w_rd_pos     = {r_rd_int, r_rd_frac};
  assign w_rd_pos_inc = w_rd_pos + POS_STEP;

  // Sign-extended sum cannot overflow; taking bits [DATA_W:1] is an
  // arithmetic shift right by one, i.e. rounding toward -inf.
  assign w_sum    = {w_q_a[DATA_W-1], w_q_a} + {w_q_b[DATA_W-1], w_q_b};
  assign w_avg    = w_sum[DATA_W:1];
  assign w_result = r_s2_frac ? w_avg : w_q_a;

  // ---------------------------------------------------------------------------
  // Sample buffer
  // ---------------------------------------------------------------------------
  pitch_dp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk     (Clk),
    .i_we      (w_we),
    .i_waddr   (r_wr_ptr),
    .i_wdata   (data_in),
    .i_re      (r_s1_valid),
    .i_raddr_a (r_s1_addr_a),
    .i_raddr_b (r_s1_addr_b),
    .o_q_a     (w_q_a),
    .o_q_b     (w_q_b)
  );

  // ---------------------------------------------------------------------------
  // Pointers, pipeline and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_int    <= '0;
      r_rd_frac   <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_frac   <= 1'b0;
      r_s1_addr_a <= '0;
      r_s1_addr_b <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_frac   <= 1'b0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      // Stage S1: capture the read position as it stands before this strobe.
      r_s1_valid <= sample_en;
      if (sample_en) begin
        r_wr_ptr    <= r_wr_ptr + 1'b1;
        r_s1_addr_a <= r_rd_int;
        r_s1_addr_b <= r_rd_int + 1'b1;
        r_s1_frac   <= r_rd_frac;

        if (w_splice) begin
          r_rd_int  <= r_rd_int + HALF_STEP;
          r_rd_frac <= 1'b0;
        end else begin
          {r_rd_int, r_rd_frac} <= w_rd_pos_inc;
        end
      end

      // Stage S2: travels alongside the registered buffer read.
      r_s2_valid <= r_s1_valid;
      r_s2_frac  <= r_s1_frac;

      // Output stage: data_out only moves when a result arrives.
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_data_out <= w_result;
      end
    end
  end

  assign data_out  = r_data_out;
  assign out_valid = r_out_valid;

endmodule : pitch_down
